// File: rtl/dcnn_pkg.sv
// Shared constants for the host row-transfer receiver.
// Provides default link/row geometry, the receiver FSM state encoding and a
// counter-width helper used by the row receiver and its deserializer.
package dcnn_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ROW_W     = 480;
  localparam int unsigned DEF_NUM_ROWS  = 32;
  localparam int unsigned DEF_ADDR_W    = 5;
  localparam int unsigned WORDS_PER_ROW = DEF_ROW_W / DEF_DATA_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_deserializer.sv
// Assembles DATA_W link words into one ROW_W row, first word in the MSBs.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   i_shift_en        accept i_data this cycle
//   i_clear           restart word counting at word 0
//   i_data            link word
//   o_last_word_c     the word being offered now is the final word of the row
//   o_row_next_c      row as it looks with i_data appended as the final word
module row_deserializer
  import dcnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ROW_W  = DEF_ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_shift_en,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_last_word_c,
  output logic [ROW_W-1:0]  o_row_next_c
);

  localparam int unsigned WORDS  = ROW_W / DATA_W;
  localparam int unsigned CNT_W  = cnt_width(WORDS);
  localparam int unsigned PART_W = ROW_W - DATA_W;

  // Only the first WORDS-1 words are stored; the final word is spliced in
  // combinationally so the row is complete on the edge that accepts it.
  logic [PART_W-1:0] r_part;
  logic [CNT_W-1:0]  r_word_cnt;

  assign o_last_word_c = (r_word_cnt == CNT_W'(WORDS - 1));
  assign o_row_next_c  = {r_part, i_data};

  // Shift register and word counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_part     <= '0;
      r_word_cnt <= '0;
    end else if (i_clear) begin
      r_word_cnt <= '0;
    end else if (i_shift_en) begin
      r_part     <= {r_part[PART_W-DATA_W-1:0], i_data};
      r_word_cnt <= o_last_word_c ? '0 : r_word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/row_receiver.sv
// Accelerator-side end of the host row-transfer link: collects link words into
// rows, writes each row to the row buffer and flags completion of an image.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   load_process    frame envelope; rising edge starts a frame, low aborts/ends it
//   send, in_data   word strobe and link word (ignored while stop=1)
//   stop            backpressure to the sender
//   row_we          one-cycle row-buffer write strobe with row_addr/row_data
//   done            full image stored; held until load_process falls
//   err_overflow    sticky: word offered after the image was complete
module row_receiver
  import dcnn_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ROW_W    = DEF_ROW_W,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_process,
  input  logic              send,
  input  logic [DATA_W-1:0] in_data,
  output logic              stop,
  output logic              row_we,
  output logic [ADDR_W-1:0] row_addr,
  output logic [ROW_W-1:0]  row_data,
  output logic              done,
  output logic              err_overflow
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_lp_prev;
  logic [ADDR_W-1:0] r_row_cnt;
  logic [ADDR_W-1:0] w_row_cnt_nxt;
  logic              r_stop;
  logic              r_row_we;
  logic [ADDR_W-1:0] r_row_addr;
  logic [ROW_W-1:0]  r_row_data;
  logic              r_done;
  logic              r_err;
  logic              w_err_nxt;
  logic              w_shift_en;
  logic              w_clear;
  logic              w_capture;
  logic              w_last_word;
  logic [ROW_W-1:0]  w_row_next;
  logic              w_lp_rise;
  logic              w_accept;

  assign w_lp_rise = load_process & ~r_lp_prev;
  assign w_accept  = send & ~r_stop;

  assign stop         = r_stop;
  assign row_we       = r_row_we;
  assign row_addr     = r_row_addr;
  assign row_data     = r_row_data;
  assign done         = r_done;
  assign err_overflow = r_err;

  row_deserializer #(
    .DATA_W (DATA_W),
    .ROW_W  (ROW_W)
  ) u_deser (
    .clk           (clk),
    .rst           (rst),
    .i_shift_en    (w_shift_en),
    .i_clear       (w_clear),
    .i_data        (in_data),
    .o_last_word_c (w_last_word),
    .o_row_next_c  (w_row_next)
  );

  // Next-state and control decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_row_cnt_nxt = r_row_cnt;
    w_err_nxt     = r_err;
    w_shift_en    = 1'b0;
    w_clear       = 1'b0;
    w_capture     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_lp_rise) begin
          w_clear       = 1'b1;
          w_row_cnt_nxt = '0;
          w_err_nxt     = 1'b0;
          w_state_nxt   = ST_RECV;
        end
      end
      ST_RECV: begin
        // Abort wins over a word offered in the same cycle.
        if (!load_process) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
          w_shift_en = 1'b1;
          if (w_last_word) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // The write strobe is already out this cycle; an abort only stops what follows.
        if (!load_process) begin
          w_state_nxt = ST_IDLE;
        end else if (r_row_cnt == ADDR_W'(NUM_ROWS - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_row_cnt_nxt = r_row_cnt + ADDR_W'(1);
          w_state_nxt   = ST_RECV;
        end
      end
      ST_DONE: begin
        if (send) begin
          w_err_nxt = 1'b1;
        end
        if (!load_process) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_lp_prev  <= 1'b0;
      r_row_cnt  <= '0;
      r_stop     <= 1'b1;
      r_row_we   <= 1'b0;
      r_row_addr <= '0;
      r_row_data <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lp_prev <= load_process;
      r_row_cnt <= w_row_cnt_nxt;
      r_err     <= w_err_nxt;
      r_stop    <= (w_state_nxt != ST_RECV);
      r_row_we  <= (w_state_nxt == ST_WRITE);
      r_done    <= (w_state_nxt == ST_DONE);
      if (w_capture) begin
        r_row_addr <= r_row_cnt;
        r_row_data <= w_row_next;
      end
    end
  end

endmodule

// File: tb/tb_row_receiver.sv
// Self-checking bench for row_receiver with a two-row image.
module tb_row_receiver;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ROW_W    = 480;
  localparam int unsigned NUM_ROWS = 2;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned WORDS    = ROW_W / DATA_W;

  logic              clk;
  logic              rst;
  logic              load_process;
  logic              send;
  logic [DATA_W-1:0] in_data;
  logic              stop;
  logic              row_we;
  logic [ADDR_W-1:0] row_addr;
  logic [ROW_W-1:0]  row_data;
  logic              done;
  logic              err_overflow;

  int checks   = 0;
  int failures = 0;

  row_receiver #(
    .DATA_W   (DATA_W),
    .ROW_W    (ROW_W),
    .NUM_ROWS (NUM_ROWS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_process (load_process),
    .send         (send),
    .in_data      (in_data),
    .stop         (stop),
    .row_we       (row_we),
    .row_addr     (row_addr),
    .row_data     (row_data),
    .done         (done),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference row: word k occupies bits [ROW_W-1-k*DATA_W -: DATA_W].
  function automatic logic [ROW_W-1:0] assemble(input logic [DATA_W-1:0] w[$]);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      r[ROW_W-1-k*DATA_W -: DATA_W] = w[k];
    end
    return r;
  endfunction

  // Offers nwords words while the receiver is collecting a row. gap=0 sends every
  // cycle, otherwise one word every gap cycles. base>0 gives words base, base+1, ...
  // Returns in the cycle after the last accepted word; counts row_we seen earlier.
  task automatic drive_row(input int base, input int gap, input int nwords,
                           output logic [ROW_W-1:0] exp_row, output int early_we);
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] w;
    int slot;
    slot = 0;
    early_we = 0;
    while (q.size() < nwords) begin
      if (gap == 0 || (slot % gap) == 0) begin
        w = (base > 0) ? DATA_W'(base + q.size()) : DATA_W'($urandom);
        send    = 1'b1;
        in_data = w;
        q.push_back(w);
      end else begin
        send    = 1'b0;
        in_data = DATA_W'($urandom);
      end
      slot++;
      tick();
      if (row_we === 1'b1 && q.size() < int'(WORDS)) early_we++;
    end
    exp_row = (nwords == int'(WORDS)) ? assemble(q) : '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load_process = 1'b0; send = 1'b0; in_data = '0;
    tick(); tick();
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL reset_stop: got %0b expected 1", stop); end
    checks++; if (row_we !== 1'b0) begin failures++; $display("FAIL reset_row_we: got %0b expected 0", row_we); end
    checks++; if (row_addr !== '0) begin failures++; $display("FAIL reset_row_addr: got %0d expected 0", row_addr); end
    checks++; if (row_data !== '0) begin failures++; $display("FAIL reset_row_data: got %0h expected 0", row_data); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err: got %0b expected 0", err_overflow); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_frame_b2b();
    logic [ROW_W-1:0] exp;
    int early;
    load_process = 1'b1; send = 1'b0;
    tick();
    checks++; if (stop !== 1'b0) begin failures++; $display("FAIL b2b_start_stop: got %0b expected 0", stop); end
    drive_row(1, 0, WORDS, exp, early);
    send = 1'b0;
    checks++; if (early !== 0) begin failures++; $display("FAIL b2b_early_we0: got %0d expected 0", early); end
    checks++; if (row_we !== 1'b1) begin failures++; $display("FAIL b2b_we0: got %0b expected 1", row_we); end
    checks++; if (row_addr !== ADDR_W'(0)) begin failures++; $display("FAIL b2b_addr0: got %0d expected 0", row_addr); end
    checks++; if (row_data !== exp) begin failures++; $display("FAIL b2b_data0: got %0h expected %0h", row_data, exp); end
    checks++; if (row_data[ROW_W-1 -: DATA_W] !== 16'h0001) begin failures++; $display("FAIL b2b_msb0: got %0h expected 1", row_data[ROW_W-1 -: DATA_W]); end
    checks++; if (row_data[DATA_W-1:0] !== 16'h001E) begin failures++; $display("FAIL b2b_lsb0: got %0h expected 1e", row_data[DATA_W-1:0]); end
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL b2b_write_stop: got %0b expected 1", stop); end
    tick();
    checks++; if (row_we !== 1'b0) begin failures++; $display("FAIL b2b_we_pulse: got %0b expected 0", row_we); end
    checks++; if (stop !== 1'b0) begin failures++; $display("FAIL b2b_recv_stop: got %0b expected 0", stop); end
    drive_row(31, 0, WORDS, exp, early);
    send = 1'b0;
    checks++; if (row_we !== 1'b1) begin failures++; $display("FAIL b2b_we1: got %0b expected 1", row_we); end
    checks++; if (row_addr !== ADDR_W'(1)) begin failures++; $display("FAIL b2b_addr1: got %0d expected 1", row_addr); end
    checks++; if (row_data !== exp) begin failures++; $display("FAIL b2b_data1: got %0h expected %0h", row_data, exp); end
    checks++; if (row_data[DATA_W-1:0] !== 16'h003C) begin failures++; $display("FAIL b2b_lsb1: got %0h expected 3c", row_data[DATA_W-1:0]); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_early: got %0b expected 0", done); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %0b expected 1", done); end
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL b2b_done_stop: got %0b expected 1", stop); end
    load_process = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_clear: got %0b expected 0", done); end
  endtask

  task automatic test_continuous_send();
    logic [ROW_W-1:0] exp;
    int early;
    load_process = 1'b1; send = 1'b0;
    tick();
    drive_row(0, 0, WORDS, exp, early);
    in_data = DATA_W'($urandom);
    checks++; if (row_we !== 1'b1 || row_data !== exp) begin failures++; $display("FAIL cont_row0: got we=%0b data=%0h expected we=1 data=%0h", row_we, row_data, exp); end
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL cont_write_stop: got %0b expected 1", stop); end
    tick();
    drive_row(0, 0, WORDS, exp, early);
    in_data = DATA_W'($urandom);
    checks++; if (early !== 0) begin failures++; $display("FAIL cont_early_we: got %0d expected 0", early); end
    checks++; if (row_we !== 1'b1 || row_addr !== ADDR_W'(1) || row_data !== exp) begin failures++; $display("FAIL cont_row1: got we=%0b addr=%0d data=%0h expected we=1 addr=1 data=%0h", row_we, row_addr, row_data, exp); end
    tick();
    send = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL cont_done: got %0b expected 1", done); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL cont_write_no_err: got %0b expected 0", err_overflow); end
    load_process = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [ROW_W-1:0] exp;
    int early;
    int n_we;
    load_process = 1'b1; send = 1'b0;
    tick();
    drive_row(0, 0, WORDS, exp, early);
    send = 1'b0;
    checks++; if (row_we !== 1'b1 || row_addr !== ADDR_W'(0)) begin failures++; $display("FAIL abort_row0: got we=%0b addr=%0d expected we=1 addr=0", row_we, row_addr); end
    tick();
    drive_row(0, 0, 10, exp, early);
    load_process = 1'b0; send = 1'b0;
    tick();
    n_we = early;
    for (int i = 0; i < 4; i++) begin
      if (row_we === 1'b1) n_we++;
      tick();
    end
    checks++; if (n_we !== 0) begin failures++; $display("FAIL abort_no_write: got %0d writes expected 0", n_we); end
    checks++; if (stop !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_idle: got stop=%0b done=%0b expected stop=1 done=0", stop, done); end
    load_process = 1'b1;
    tick();
    drive_row(0, 0, WORDS, exp, early);
    send = 1'b0;
    checks++; if (early !== 0) begin failures++; $display("FAIL abort_restart_early: got %0d expected 0", early); end
    checks++; if (row_we !== 1'b1 || row_addr !== ADDR_W'(0) || row_data !== exp) begin failures++; $display("FAIL abort_restart: got we=%0b addr=%0d data=%0h expected we=1 addr=0 data=%0h", row_we, row_addr, row_data, exp); end
    load_process = 1'b0;
    tick();
    checks++; if (row_we !== 1'b0 || stop !== 1'b1) begin failures++; $display("FAIL abort_in_write: got we=%0b stop=%0b expected we=0 stop=1", row_we, stop); end
  endtask

  task automatic test_overflow();
    logic [ROW_W-1:0] exp;
    int early;
    load_process = 1'b1; send = 1'b0;
    tick();
    drive_row(0, 0, WORDS, exp, early);
    send = 1'b0;
    tick();
    drive_row(0, 0, WORDS, exp, early);
    send = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_done: got done=%0b err=%0b expected done=1 err=0", done, err_overflow); end
    send = 1'b1; in_data = DATA_W'($urandom);
    tick();
    send = 1'b0;
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %0b expected 1", err_overflow); end
    tick(); tick(); tick();
    checks++; if (err_overflow !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL ovf_hold: got err=%0b done=%0b expected err=1 done=1", err_overflow, done); end
    load_process = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || err_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got done=%0b err=%0b expected done=0 err=1", done, err_overflow); end
    load_process = 1'b1;
    tick();
    checks++; if (err_overflow !== 1'b0 || stop !== 1'b0) begin failures++; $display("FAIL ovf_clear: got err=%0b stop=%0b expected err=0 stop=0", err_overflow, stop); end
    load_process = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_row();
    logic [ROW_W-1:0] exp;
    int early;
    int n_we;
    load_process = 1'b1; send = 1'b0;
    tick();
    drive_row(0, 0, 15, exp, early);
    rst = 1'b0;
    send = 1'b1; in_data = DATA_W'($urandom);
    tick();
    checks++; if (stop !== 1'b1 || row_we !== 1'b0 || done !== 1'b0 || err_overflow !== 1'b0) begin failures++; $display("FAIL midrst_flags: got stop=%0b we=%0b done=%0b err=%0b expected 1 0 0 0", stop, row_we, done, err_overflow); end
    checks++; if (row_addr !== '0 || row_data !== '0) begin failures++; $display("FAIL midrst_row: got addr=%0d data=%0h expected 0 0", row_addr, row_data); end
    rst = 1'b1; load_process = 1'b0; send = 1'b0;
    n_we = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (row_we === 1'b1) n_we++;
    end
    checks++; if (n_we !== 0 || stop !== 1'b1) begin failures++; $display("FAIL midrst_no_write: got writes=%0d stop=%0b expected 0 1", n_we, stop); end
  endtask

  task automatic test_gapped();
    logic [ROW_W-1:0] exp;
    int early;
    load_process = 1'b1; send = 1'b0;
    tick();
    drive_row(1, 3, WORDS, exp, early);
    send = 1'b0;
    checks++; if (early !== 0) begin failures++; $display("FAIL gap_early_we: got %0d expected 0", early); end
    checks++; if (row_we !== 1'b1 || row_data !== exp) begin failures++; $display("FAIL gap_row0: got we=%0b data=%0h expected we=1 data=%0h", row_we, row_data, exp); end
    checks++; if (row_data[ROW_W-1 -: DATA_W] !== 16'h0001 || row_data[DATA_W-1:0] !== 16'h001E) begin failures++; $display("FAIL gap_ends0: got %0h/%0h expected 1/1e", row_data[ROW_W-1 -: DATA_W], row_data[DATA_W-1:0]); end
    tick();
    checks++; if (row_we !== 1'b0) begin failures++; $display("FAIL gap_we_pulse: got %0b expected 0", row_we); end
    drive_row(31, 3, WORDS, exp, early);
    send = 1'b0;
    checks++; if (row_we !== 1'b1 || row_addr !== ADDR_W'(1) || row_data !== exp) begin failures++; $display("FAIL gap_row1: got we=%0b addr=%0d data=%0h expected we=1 addr=1 data=%0h", row_we, row_addr, row_data, exp); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gap_done: got %0b expected 1", done); end
    load_process = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_b2b();
    test_continuous_send();
    test_abort();
    test_overflow();
    test_reset_mid_row();
    test_gapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
